axi_wr_arb: RTL and testbench
=============================

# axi_wr_arb

Two-requester write arbiter placed in front of the single AXI4 write master that drives the DDR3 controller's write-slave interface. It accepts burst write requests from two user ports, such as two video/frame FIFO channels, and grants the shared master to one port per burst using round-robin. It latches that port's address and length, steers the master's data-request strobe and write data between the granted port and the master, and returns a per-port completion pulse. The grant is held until the master reports the burst complete.

## Interface
- ADDR_W, 30, byte address width
- DATA_W, 64, write data width
- TIMEOUT_CYC, 4095, watchdog limit in clk cycles (used only with the macro in Configuration)
- clk  in  1  system clock; everything is sampled on its rising edge
- rst_n  in  1  reset, synchronous and active-low
- req0 / req1  in  1  burst request from port 0 / port 1; must be held high until that port's grant
- addr0 / addr1  in  ADDR_W  burst start address; must be stable while the request is high
- len0 / len1  in  8  burst length minus 1 (AXI awlen encoding); must be stable while the request is high
- wdata0 / wdata1  in  DATA_W  write data, valid in the cycle the port's data_req is high
- gnt0 / gnt1  out  1  grant level, high from the grant cycle through the done cycle
- data_req0 / data_req1  out  1  data strobe to the port, equal to m_data_req AND the port's grant
- done0 / done1  out  1  one-cycle completion pulse to the port
- m_start  out  1  one-cycle burst start pulse to the write master
- m_addr  out  ADDR_W  latched burst address
- m_len  out  8  latched burst length
- m_wdata  out  DATA_W  combinational mux of the granted port's wdata; 0 when no port is granted
- m_data_req  in  1  master pulls one beat this cycle
- m_done  in  1  master one-cycle pulse: write response handshake complete
- err  out  1  one-cycle pulse on watchdog abort (tied 0 when the watchdog is compiled out)

## Operation
- States: IDLE, GRANT, BUSY, DONE. The encoding is one-hot or binary; the encoding choice is not observable at the ports.
- IDLE: if req0 or req1 is high, choose a winner, register gnt, m_addr and m_len from the winner, and go to GRANT. Otherwise stay in IDLE.
- Winner selection:
  - Only one port requesting: that port wins.
  - Both requesting: the port that did not win the previous arbitration wins.
  - last_winner resets to 1, so port 0 wins the first tie after reset.
- GRANT: m_start is high for exactly this cycle. Unconditional transition to BUSY.
- BUSY:
  - data_req and m_wdata are steered to the granted port only. The ungranted port's data_req is 0.
  - On m_done: go to DONE.
  - m_done received in the GRANT cycle is also accepted and goes straight to DONE.
- DONE: the granted port's done pulse is high for this cycle, and gnt drops at the end of it. Go to IDLE.
- m_addr and m_len hold their value from grant until the next grant. They are not cleared on done.
- A request that drops before it is granted is ignored. A request that drops while granted does not abort the burst; the burst completes.
- A port that holds req high continuously is re-arbitrated in the next IDLE. With both ports requesting, the ports alternate.

## Timing
- Reset values: gnt0 = gnt1 = 0, data_req0 = data_req1 = 0, done0 = done1 = 0, m_start = 0, m_addr = 0, m_len = 0, m_wdata = 0, err = 0. State resets to IDLE and last_winner to 1.
- Reset asserted mid-burst: on the next edge all outputs take their reset values and state returns to IDLE. The master is reset by the same rst_n.
- Latency:
  - req high in cycle N (in IDLE) → gnt high and state GRANT in N+1, m_start high in N+1.
  - m_done in cycle M → done pulse in M+1, IDLE in M+2.
  - The earliest next grant is M+3. The minimum gap between bursts is two cycles.
- data_req_x and m_wdata are combinational from m_data_req and the grant register, with no added pipeline delay.
- m_done while in IDLE or DONE is ignored.

## Configuration
- AXI_WR_ARB_TIMEOUT_EN defined: a 16-bit watchdog counter clears at GRANT and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYC without m_done: err pulses high for one cycle and the FSM goes to DONE.
  - The granted port receives its done pulse in the following cycle, and the arbiter returns to IDLE normally.
- AXI_WR_ARB_TIMEOUT_EN undefined: no counter exists, err is tied 0, and BUSY waits for m_done indefinitely.

## Test plan
- Single request:
  - Stimulus: req0 with addr0 = 0x0000100, len0 = 15; master returns 16 data_req beats, then m_done.
  - Required: m_start one cycle after req0, m_addr = 0x0000100, m_len = 15, 16 data_req0 pulses, zero data_req1 pulses, done0 one cycle after m_done, and gnt0 low two cycles after m_done.
- Tie after reset:
  - Stimulus: req0 and req1 rise in the same cycle.
  - Required: port 0 is granted first. After done0, port 1 is granted with m_addr = addr1.
- Continuous contention: req0 and req1 held high for 6 bursts → grants alternate 0,1,0,1,0,1.
- Data steering: during a port 1 burst with wdata0 = 0xAAAA… and wdata1 = 0x5555… → m_wdata = 0x5555… on every data_req beat.
- Reset mid-burst: rst_n low for one cycle in BUSY → every output takes its reset value on the next edge, and a new req1 is granted normally.
- Watchdog (macro defined, TIMEOUT_CYC = 20):
  - Stimulus: no m_done.
  - Required: err pulses 20 BUSY cycles after GRANT, and done0 follows one cycle later.
  - With the macro undefined: err stays 0 and gnt0 stays high.

Source files
------------

// File: rtl/axi_wr_arb.sv
// axi_wr_arb: two-port round-robin burst arbiter in front of one AXI4 write master.
// Latency: request to grant/m_start is 1 cycle; m_done to done pulse is 1 cycle, back to IDLE in 2.
// Backpressure: requests wait while a burst is in flight; the master paces beats through m_data_req.
// Optional watchdog: define AXI_WR_ARB_TIMEOUT_EN to abort bursts that never see m_done.

module axi_wr_arb #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [7:0]        len0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              data_req0,
  output logic              done0,

  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        len1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              data_req1,
  output logic              done1,

  output logic              m_start,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_len,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_data_req,
  input  logic              m_done,

  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Grant levels and latched burst descriptor of the current owner.
  logic              gnt0_q;
  logic              gnt1_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;

  // 1 when port 1 won the most recent arbitration.
  logic              last_winner;

  logic              any_req;
  logic              win1;
  logic              arb_fire;
  logic              timeout;

  assign any_req  = req0 | req1;
  // Port 1 wins when it is alone, or on a tie when port 0 won last time.
  assign win1     = req1 & (~req0 | ~last_winner);
  assign arb_fire = (state == S_IDLE) & any_req;

`ifdef AXI_WR_ARB_TIMEOUT_EN
  // Last BUSY count before the abort fires: the abort lands on the
  // TIMEOUT_CYC-th BUSY cycle after GRANT.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wd_cnt;

  // Watchdog counter: cleared in GRANT, counts every BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == S_GRANT) begin
      wd_cnt <= '0;
    end else if (state == S_BUSY) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  // A real completion in the same cycle takes precedence over the abort.
  assign timeout = (state == S_BUSY) & (wd_cnt == WD_LAST) & ~m_done;
`else
  // Watchdog compiled out: the limit is kept only so the parameter list is
  // identical in both builds.
  localparam int wd_limit_unused = TIMEOUT_CYC;

  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; m_done is honoured in GRANT and BUSY only.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (m_done) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (m_done || timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant, round-robin history and burst descriptor: loaded on arbitration,
  // grant dropped at the end of DONE, descriptor held until the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      last_winner <= 1'b1;
      addr_q      <= '0;
      len_q       <= '0;
    end else if (arb_fire) begin
      gnt0_q      <= ~win1;
      gnt1_q      <= win1;
      last_winner <= win1;
      addr_q      <= win1 ? addr1 : addr0;
      len_q       <= win1 ? len1  : len0;
    end else if (state == S_DONE) begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
    end
  end

  // Output decode: strobes and data steering are combinational from the grant.
  always_comb begin
    gnt0      = gnt0_q;
    gnt1      = gnt1_q;
    m_start   = (state == S_GRANT);
    m_addr    = addr_q;
    m_len     = len_q;
    done0     = (state == S_DONE) & gnt0_q;
    done1     = (state == S_DONE) & gnt1_q;
    data_req0 = m_data_req & gnt0_q;
    data_req1 = m_data_req & gnt1_q;
    err       = timeout;
    m_wdata   = '0;
    if (gnt0_q) begin
      m_wdata = wdata0;
    end else if (gnt1_q) begin
      m_wdata = wdata1;
    end
  end

endmodule

// File: tb/tb_axi_wr_arb.sv
// Directed bench for axi_wr_arb with a grant/data scoreboard.
module tb_axi_wr_arb;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [7:0]        len0, len1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, data_req0, data_req1, done0, done1;
  logic              m_start;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_len;
  logic [DATA_W-1:0] m_wdata;
  logic              m_data_req, m_done, err;

  axi_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .len0(len0), .wdata0(wdata0),
    .gnt0(gnt0), .data_req0(data_req0), .done0(done0),
    .req1(req1), .addr1(addr1), .len1(len1), .wdata1(wdata1),
    .gnt1(gnt1), .data_req1(data_req1), .done1(done1),
    .m_start(m_start), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
    .m_data_req(m_data_req), .m_done(m_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                port;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    int                req_cyc;
  } exp_t;

  exp_t        gq[$];
  logic [63:0] dq[$];

  int passes = 0;
  int total  = 0;
  int mdone_cyc = 0;
  bit fixed_pat = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push_grant(input int port, input int req_cyc);
    exp_t e;
    e.port    = port;
    e.addr    = port ? addr1 : addr0;
    e.len     = port ? len1 : len0;
    e.req_cyc = req_cyc;
    gq.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_gnt"},      {62'd0, gnt0, gnt1}, 0);
    chk({tag, "_data_req"}, {62'd0, data_req0, data_req1}, 0);
    chk({tag, "_done"},     {62'd0, done0, done1}, 0);
    chk({tag, "_m_start"},  {63'd0, m_start}, 0);
    chk({tag, "_m_addr"},   {34'd0, m_addr}, 0);
    chk({tag, "_m_len"},    {56'd0, m_len}, 0);
    chk({tag, "_m_wdata"},  m_wdata, 0);
    chk({tag, "_err"},      {63'd0, err}, 0);
  endtask

  task automatic wait_start(output bit seen);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_start === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("m_start_seen", {63'd0, seen}, 1);
  endtask

  // Waits for the next grant, checks it against the scoreboard, plays the
  // burst as the master would, then checks completion and release.
  task automatic serve(input bit chk_gap, input bit drop_reqs);
    exp_t        e;
    bit          seen;
    int          c0, c1;
    logic [63:0] exp_d;
    c0 = 0;
    c1 = 0;
    wait_start(seen);
    if (!seen) return;
    chk("sb_nonempty", (gq.size() > 0) ? 64'd1 : 64'd0, 1);
    if (gq.size() == 0) return;
    e = gq.pop_front();
    chk("gnt0", {63'd0, gnt0}, (e.port == 0) ? 64'd1 : 64'd0);
    chk("gnt1", {63'd0, gnt1}, (e.port == 1) ? 64'd1 : 64'd0);
    chk("m_addr", {34'd0, m_addr}, {34'd0, e.addr});
    chk("m_len", {56'd0, m_len}, {56'd0, e.len});
    if (e.req_cyc >= 0) chk("start_latency", 64'(cyc - e.req_cyc), 1);
    if (chk_gap) chk("burst_gap", 64'(cyc - mdone_cyc), 3);
    for (int b = 0; b <= int'(e.len); b++) begin
      @(posedge clk); #1;
      if (!fixed_pat) begin
        wdata0 = {$urandom, $urandom};
        wdata1 = {$urandom, $urandom};
      end
      dq.push_back(e.port ? wdata1 : wdata0);
      m_data_req = 1;
      @(negedge clk);
      c0 += int'(data_req0);
      c1 += int'(data_req1);
      exp_d = dq.pop_front();
      chk("m_wdata", m_wdata, exp_d);
    end
    @(posedge clk); #1;
    m_data_req = 0;
    m_done     = 1;
    mdone_cyc  = cyc;
    @(negedge clk);
    chk("done_early", {62'd0, done0, done1}, 0);
    @(posedge clk); #1;
    m_done = 0;
    @(negedge clk);
    chk("done_port",  {63'd0, e.port ? done1 : done0}, 1);
    chk("done_other", {63'd0, e.port ? done0 : done1}, 0);
    chk("gnt_in_done", {63'd0, e.port ? gnt1 : gnt0}, 1);
    if (drop_reqs) begin
      req0 = 0;
      req1 = 0;
    end
    @(negedge clk);
    chk("gnt_released", {62'd0, gnt0, gnt1}, 0);
    chk("done_cleared", {62'd0, done0, done1}, 0);
    chk("m_addr_hold", {34'd0, m_addr}, {34'd0, e.addr});
    chk("data_req_port",  64'(e.port ? c1 : c0), 64'(int'(e.len) + 1));
    chk("data_req_other", 64'(e.port ? c0 : c1), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    bit seen;
    int g, err_c, done_c, nerr;

    rst_n      = 0;
    req0       = 0;
    req1       = 0;
    addr0      = '0;
    addr1      = '0;
    len0       = '0;
    len1       = '0;
    wdata0     = '1;
    wdata1     = '1;
    m_data_req = 1;
    m_done     = 0;

    // Power-on reset, with m_data_req and wdata active to show they are masked.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    rst_n      = 1;
    m_data_req = 0;

    // m_done while idle must not produce anything.
    @(posedge clk); #1;
    m_done = 1;
    @(posedge clk); #1;
    m_done = 0;
    @(negedge clk);
    chk("idle_mdone", {59'd0, gnt0, gnt1, done0, done1, m_start}, 0);

    // Single request on port 0, 16-beat burst.
    @(posedge clk); #1;
    addr0 = 30'h0000100;
    len0  = 8'd15;
    req0  = 1;
    push_grant(0, cyc);
    serve(0, 1);

    // Tie after reset, then continuous contention: strict alternation.
    do_reset();
    @(posedge clk); #1;
    fixed_pat = 1;
    wdata0 = 64'hAAAA_AAAA_AAAA_AAAA;
    wdata1 = 64'h5555_5555_5555_5555;
    addr0  = 30'h0002000;
    addr1  = 30'h0003000;
    len0   = 8'd3;
    len1   = 8'd5;
    req0   = 1;
    req1   = 1;
    for (int i = 0; i < 8; i++) push_grant(i % 2, (i == 0) ? cyc : -1);
    for (int i = 0; i < 8; i++) serve(i > 0, i == 7);
    fixed_pat = 0;

    // Reset in the middle of a port 1 burst.
    @(posedge clk); #1;
    addr1 = 30'h0004444;
    len1  = 8'd9;
    req1  = 1;
    wait_start(seen);
    chk("rst_burst_m_addr", {34'd0, m_addr}, {34'd0, 30'h0004444});
    @(posedge clk); #1;
    req1       = 0;
    m_data_req = 1;
    @(negedge clk);
    chk("rst_burst_data_req1", {62'd0, data_req0, data_req1}, 1);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check_reset("mid_rst");
    m_data_req = 0;
    @(posedge clk); #1;
    addr1 = 30'h0005550;
    len1  = 8'd2;
    req1  = 1;
    push_grant(1, cyc);
    serve(0, 1);

    // Burst that never sees m_done.
    @(posedge clk); #1;
    addr0 = 30'h0006000;
    len0  = 8'd7;
    req0  = 1;
    wait_start(seen);
    g = cyc;
    @(posedge clk); #1;
    req0 = 0;
    nerr = 0;
`ifdef AXI_WR_ARB_TIMEOUT_EN
    err_c  = -1;
    done_c = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (err) begin
        nerr++;
        if (err_c < 0) err_c = cyc;
      end
      if (done0 && done_c < 0) done_c = cyc;
    end
    chk("wd_err_cycle",  64'(err_c - g), 20);
    chk("wd_done_cycle", 64'(done_c - g), 21);
    chk("wd_err_pulses", 64'(nerr), 1);
    chk("wd_gnt_released", {62'd0, gnt0, gnt1}, 0);
`else
    err_c  = 0;
    done_c = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      nerr   += int'(err);
      done_c += int'(done0);
    end
    chk("nowd_err_pulses", 64'(nerr), 0);
    chk("nowd_done0", 64'(done_c + err_c), 0);
    chk("nowd_gnt0_held", {63'd0, gnt0}, 1);
`endif
    do_reset();
    @(negedge clk);
    check_reset("end_rst");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
